// File: rtl/samp_rate_sched.sv
// ---------------------------------------------------------------------------
// samp_rate_sched
//
// Purpose:
//   Sample-rate scheduler for the DDS function generator. It generates the
//   sample-enable strobe that paces the waveform datapath. Rate-change
//   requests from the front-panel button and from the host register interface
//   are arbitrated. A new rate is applied only on a sample boundary, so the
//   datapath never receives a partial sample period. The block also times the
//   power-up interval that follows reset.
//
// Ports:
//   Fg_CLK       in   1  system clock; all logic runs on its rising edge
//   RESET        in   1  synchronous, active-high reset
//   IntBTN       in   1  raw, asynchronous front-panel button
//   HostReq      in   1  host rate-change request (one-cycle pulse)
//   HostMode     in   3  requested mode, sampled when HostReq=1
//   HostAck      out  1  one-cycle pulse when the host's mode is applied
//   HostErr      out  1  one-cycle pulse when a host request is rejected
//   Mode         out  3  currently active mode (divisor 10**Mode)
//   Enable       out  1  sample-enable strobe
//   Ready        out  1  high once the startup interval has completed
//   Busy         out  1  high while a mode change is pending
//   DropCnt      out  8  saturating count of dropped/overridden requests
//                        (present only when SAMP_SCHED_STATUS_EN is defined)
//
// Optional build macro: SAMP_SCHED_STATUS_EN (adds DropCnt and its counter).
// ---------------------------------------------------------------------------
module samp_rate_sched #(
  parameter int NUM_MODES   = 5,
  parameter int CNT_W       = 15,
  parameter int DEB_CYC     = 16,
  parameter int STARTUP_CYC = 80
) (
  input  logic       Fg_CLK,
  input  logic       RESET,
  input  logic       IntBTN,
  input  logic       HostReq,
  input  logic [2:0] HostMode,
  output logic       HostAck,
  output logic       HostErr,
  output logic [2:0] Mode,
  output logic       Enable,
`ifdef SAMP_SCHED_STATUS_EN
  output logic [7:0] DropCnt,
`endif
  output logic       Ready,
  output logic       Busy
);

  localparam int START_W = $clog2(STARTUP_CYC + 1);
  localparam int DEB_W   = $clog2(DEB_CYC + 1);

  localparam logic [START_W-1:0] START_LAST = START_W'(STARTUP_CYC - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYC - 1);
  localparam logic [2:0]         LAST_MODE  = 3'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    S_STARTUP = 2'd0,
    S_RUN     = 2'd1,
    S_PEND    = 2'd2
  } state_t;

  state_t             r_state;
  logic [START_W-1:0] r_start_cnt;
  logic [CNT_W-1:0]   r_div_cnt;
  logic [2:0]         r_mode;
  logic               r_enable;
  logic               r_ready;
  logic               r_busy;
  logic               r_host_ack;
  logic               r_host_err;
  logic [2:0]         r_pend_target;
  logic               r_pend_host;

  // Button synchroniser and debouncer
  logic               r_btn_s1;
  logic               r_btn_s2;
  logic               r_btn_level;
  logic [DEB_W-1:0]   r_deb_cnt;

  // Terminal count (divisor - 1) per mode; unused slots read as zero.
  logic [7:0][CNT_W-1:0] w_div_tab;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_div_tab
      if (gi < NUM_MODES) begin : g_used
        assign w_div_tab[gi] = CNT_W'(10**gi - 1);
      end else begin : g_unused
        assign w_div_tab[gi] = '0;
      end
    end
  endgenerate

  logic [CNT_W-1:0] w_div_last;
  logic             w_div_wrap;
  logic             w_host_valid;
  logic             w_host_bad;
  logic             w_btn_evt;
  logic [2:0]       w_btn_target;
  logic [2:0]       w_eff_target;
  logic             w_eff_host;

  assign w_div_last   = w_div_tab[r_mode];
  assign w_div_wrap   = (r_div_cnt == w_div_last);
  assign w_host_valid = HostReq && (HostMode <= LAST_MODE);
  assign w_host_bad   = HostReq && (HostMode > LAST_MODE);
  assign w_btn_target = (r_mode == LAST_MODE) ? 3'd0 : r_mode + 3'd1;

  // A host request arriving while a change is pending overrides the target.
  assign w_eff_target = w_host_valid ? HostMode : r_pend_target;
  assign w_eff_host   = w_host_valid | r_pend_host;

  // Press event: the synchronised level has differed from the accepted level
  // for DEB_CYC consecutive cycles and is about to be accepted as high.
  assign w_btn_evt = (r_btn_s2 != r_btn_level) && (r_deb_cnt == DEB_LAST) && r_btn_s2;

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      r_btn_s1    <= 1'b0;
      r_btn_s2    <= 1'b0;
      r_btn_level <= 1'b0;
      r_deb_cnt   <= '0;
    end else begin
      r_btn_s1 <= IntBTN;
      r_btn_s2 <= r_btn_s1;
      if (r_btn_s2 != r_btn_level) begin
        if (r_deb_cnt == DEB_LAST) begin
          r_btn_level <= r_btn_s2;
          r_deb_cnt   <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      r_state       <= S_STARTUP;
      r_start_cnt   <= '0;
      r_div_cnt     <= '0;
      r_mode        <= '0;
      r_enable      <= 1'b0;
      r_ready       <= 1'b0;
      r_busy        <= 1'b0;
      r_host_ack    <= 1'b0;
      r_host_err    <= 1'b0;
      r_pend_target <= '0;
      r_pend_host   <= 1'b0;
    end else begin
      r_host_ack <= 1'b0;
      r_host_err <= 1'b0;
      case (r_state)
        S_STARTUP: begin
          if (r_start_cnt == START_LAST) begin
            r_ready   <= 1'b1;
            r_state   <= S_RUN;
            r_div_cnt <= '0;
            // Mode is always 0 here, so the strobe starts continuous.
            r_enable  <= (w_div_last == '0);
          end else begin
            r_start_cnt <= r_start_cnt + 1'b1;
          end
        end

        S_RUN: begin
          r_div_cnt  <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
          r_enable   <= w_div_wrap;
          r_host_err <= w_host_bad;
          if (w_host_valid) begin
            r_pend_target <= HostMode;
            r_pend_host   <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= S_PEND;
          end else if (w_btn_evt) begin
            r_pend_target <= w_btn_target;
            r_pend_host   <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_PEND;
          end
        end

        S_PEND: begin
          r_host_err <= w_host_bad;
          if (r_enable) begin
            // Sample boundary: switch rate and restart the divider.
            r_mode     <= w_eff_target;
            r_div_cnt  <= '0;
            r_enable   <= (w_eff_target == 3'd0);
            r_busy     <= 1'b0;
            r_host_ack <= w_eff_host;
            r_state    <= S_RUN;
          end else begin
            r_div_cnt     <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
            r_enable      <= w_div_wrap;
            r_pend_target <= w_eff_target;
            r_pend_host   <= w_eff_host;
          end
        end

        default: r_state <= S_STARTUP;
      endcase
    end
  end

`ifdef SAMP_SCHED_STATUS_EN
  // Number of requests lost this cycle: a button event beaten by a host
  // request, a button event during PEND, or a pending target overridden.
  logic [1:0] w_drop_inc;
  logic [8:0] w_drop_sum;
  logic [7:0] r_drop_cnt;

  always_comb begin
    w_drop_inc = 2'd0;
    if (r_state == S_RUN) begin
      w_drop_inc = {1'b0, w_host_valid & w_btn_evt};
    end else if (r_state == S_PEND) begin
      w_drop_inc = {1'b0, w_host_valid} + {1'b0, w_btn_evt};
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  assign DropCnt = r_drop_cnt;
`endif

  assign HostAck = r_host_ack;
  assign HostErr = r_host_err;
  assign Mode    = r_mode;
  assign Enable  = r_enable;
  assign Ready   = r_ready;
  assign Busy    = r_busy;

endmodule

// File: tb/tb_samp_rate_sched.sv
// ---------------------------------------------------------------------------
// tb_samp_rate_sched
//
// Directed bench for samp_rate_sched. A behavioural model (startup timer,
// debounced button, modulo-arithmetic sample clock, pending-request slot) is
// stepped on every rising edge; a compare process checks every DUT output
// against it on every falling edge. Directed sequences add literal checks at
// hand-computed cycle offsets.
// ---------------------------------------------------------------------------
module tb_samp_rate_sched;

  localparam int NUM_MODES   = 5;
  localparam int DEB_CYC     = 16;
  localparam int STARTUP_CYC = 80;

  logic       clk = 1'b0;
  logic       RESET;
  logic       IntBTN;
  logic       HostReq;
  logic [2:0] HostMode;
  logic       HostAck;
  logic       HostErr;
  logic [2:0] Mode;
  logic       Enable;
  logic       Ready;
  logic       Busy;
`ifdef SAMP_SCHED_STATUS_EN
  logic [7:0] DropCnt;
`endif

  always #5 clk = ~clk;

  samp_rate_sched dut (
    .Fg_CLK   (clk),
    .RESET    (RESET),
    .IntBTN   (IntBTN),
    .HostReq  (HostReq),
    .HostMode (HostMode),
    .HostAck  (HostAck),
    .HostErr  (HostErr),
    .Mode     (Mode),
    .Enable   (Enable),
`ifdef SAMP_SCHED_STATUS_EN
    .DropCnt  (DropCnt),
`endif
    .Ready    (Ready),
    .Busy     (Busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ready, m_start, m_mode, m_since, m_en, m_busy, m_tgt, m_host;
  int m_ack, m_err, m_drop;
  int m_d1, m_d2, m_acc, m_run;
  bit m_seen_rst = 1'b0;

  function automatic int divisor(input int k);
    int d = 1;
    for (int i = 0; i < k; i++) d = d * 10;
    return d;
  endfunction

  task automatic drop_add();
    if (m_drop < 255) m_drop++;
  endtask

  // One sample period later in the current mode.
  task automatic advance();
    m_since++;
    m_en = (m_mode == 0) || (m_since % divisor(m_mode) == 0);
  endtask

  task automatic model_step();
    int  seen;
    bit  evt;
    bit  hv;
    if (RESET) begin
      m_ready = 0; m_start = 0; m_mode = 0; m_since = 0; m_en = 0;
      m_busy = 0; m_tgt = 0; m_host = 0; m_ack = 0; m_err = 0; m_drop = 0;
      m_d1 = 0; m_d2 = 0; m_acc = 0; m_run = 0;
      m_seen_rst = 1'b1;
    end else begin
      // Two-stage synchroniser, then accept a level held DEB_CYC cycles.
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = int'(IntBTN);
      evt  = 1'b0;
      if (seen != m_acc) begin
        m_run++;
        if (m_run == DEB_CYC) begin
          m_acc = seen;
          m_run = 0;
          evt   = (seen == 1);
        end
      end else begin
        m_run = 0;
      end

      m_ack = 0;
      m_err = 0;
      if (m_ready == 0) begin
        m_start++;
        if (m_start == STARTUP_CYC) begin
          m_ready = 1;
          m_since = 0;
          m_en    = (m_mode == 0);
        end
      end else begin
        hv    = HostReq && (int'(HostMode) < NUM_MODES);
        m_err = (HostReq && !hv) ? 1 : 0;
        if (m_busy != 0) begin
          if (hv) begin
            m_tgt  = int'(HostMode);
            m_host = 1;
            drop_add();
          end
          if (evt) drop_add();
          if (m_en != 0) begin
            m_mode  = m_tgt;
            m_since = 0;
            m_en    = (m_mode == 0);
            m_busy  = 0;
            m_ack   = m_host;
          end else begin
            advance();
          end
        end else begin
          advance();
          if (hv) begin
            m_tgt  = int'(HostMode);
            m_host = 1;
            m_busy = 1;
            if (evt) drop_add();
          end else if (evt) begin
            m_tgt  = (m_mode == NUM_MODES - 1) ? 0 : m_mode + 1;
            m_host = 0;
            m_busy = 1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (m_seen_rst) begin
      chk("mdl_mode",   int'(Mode),    m_mode);
      chk("mdl_enable", int'(Enable),  m_en);
      chk("mdl_ready",  int'(Ready),   m_ready);
      chk("mdl_busy",   int'(Busy),    m_busy);
      chk("mdl_ack",    int'(HostAck), m_ack);
      chk("mdl_err",    int'(HostErr), m_err);
`ifdef SAMP_SCHED_STATUS_EN
      chk("mdl_drop",   int'(DropCnt), m_drop);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_req(input int m);
    HostReq  = 1'b1;
    HostMode = 3'(m);
    tick(1);
    HostReq  = 1'b0;
    HostMode = 3'd0;
  endtask

  task automatic wait_ack(input int limit, input string name);
    int n   = 0;
    bit got = 1'b0;
    while (!got && n < limit) begin
      tick(1);
      n++;
      if (HostAck) got = 1'b1;
    end
    chk(name, int'(got), 1);
  endtask

  task automatic count_pulses(input int cycles, input int exp, input string name);
    int c = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (Enable) c++;
    end
    chk(name, c, exp);
  endtask

  task automatic press_and_apply(input int exp_mode);
    int n = 0;
    IntBTN = 1'b1;
    tick(20);
    IntBTN = 1'b0;
    while (Busy && n < 12000) begin
      tick(1);
      n++;
    end
    chk("wrap_busy_clear", int'(Busy), 0);
    tick(20);
    chk("wrap_mode", int'(Mode), exp_mode);
  endtask

  initial begin
    RESET    = 1'b1;
    IntBTN   = 1'b0;
    HostReq  = 1'b0;
    HostMode = 3'd0;
    tick(3);

    // 1: startup interval
    chk("rst_mode", int'(Mode), 0);
    chk("rst_ready", int'(Ready), 0);
    chk("rst_enable", int'(Enable), 0);
    RESET = 1'b0;
    tick(79);
    chk("t1_ready_low_79", int'(Ready), 0);
    chk("t1_enable_low_79", int'(Enable), 0);
    tick(1);
    chk("t1_ready_80", int'(Ready), 1);
    chk("t1_enable_80", int'(Enable), 1);
    chk("t1_mode_80", int'(Mode), 0);
    count_pulses(20, 20, "t1_continuous_enable");

    // 2: button press, mode 0 -> 1, held for 1000 cycles
    IntBTN = 1'b1;
    tick(18);
    chk("t2_busy", int'(Busy), 1);
    chk("t2_mode_before", int'(Mode), 0);
    tick(1);
    chk("t2_mode_after", int'(Mode), 1);
    chk("t2_busy_clear", int'(Busy), 0);
    tick(9);
    chk("t2_en_9", int'(Enable), 0);
    tick(1);
    chk("t2_en_10", int'(Enable), 1);
    tick(1);
    chk("t2_en_11", int'(Enable), 0);
    tick(970);
    IntBTN = 1'b0;
    tick(30);
    chk("t2_single_change", int'(Mode), 1);
    count_pulses(100, 10, "t2_pulses_per_100");

    // 3: mode 3, host asks for mode 1 at divider count 200
    host_req(3);
    wait_ack(20, "t3_ack_to3");
    chk("t3_mode3", int'(Mode), 3);
    tick(200);
    host_req(1);
    chk("t3_busy", int'(Busy), 1);
    chk("t3_mode_hold", int'(Mode), 3);
    tick(799);
    chk("t3_boundary_en", int'(Enable), 1);
    chk("t3_mode_still3", int'(Mode), 3);
    chk("t3_no_early_ack", int'(HostAck), 0);
    tick(1);
    chk("t3_mode1", int'(Mode), 1);
    chk("t3_ack", int'(HostAck), 1);
    chk("t3_busy_clear", int'(Busy), 0);
    tick(1);
    chk("t3_ack_one_pulse", int'(HostAck), 0);
    tick(8);
    chk("t3_en_9", int'(Enable), 0);
    tick(1);
    chk("t3_en_10", int'(Enable), 1);

    // 4: invalid host requests
    host_req(6);
    chk("t4_err6", int'(HostErr), 1);
    chk("t4_busy6", int'(Busy), 0);
    chk("t4_mode6", int'(Mode), 1);
    tick(1);
    chk("t4_err_one_pulse", int'(HostErr), 0);
    host_req(5);
    chk("t4_err5", int'(HostErr), 1);
    count_pulses(100, 10, "t4_period_kept");

    // 5: host and button in the same cycle in mode 0, then wrap
    host_req(0);
    wait_ack(20, "t5_ack_to0");
    chk("t5_mode0", int'(Mode), 0);
    tick(3);
    IntBTN = 1'b1;
    tick(17);
    HostReq  = 1'b1;
    HostMode = 3'd2;
    tick(1);
    HostReq  = 1'b0;
    HostMode = 3'd0;
    chk("t5_busy", int'(Busy), 1);
    tick(1);
    chk("t5_mode2", int'(Mode), 2);
    chk("t5_ack", int'(HostAck), 1);
`ifdef SAMP_SCHED_STATUS_EN
    chk("t5_dropcnt", int'(DropCnt), 1);
`endif
    IntBTN = 1'b0;
    tick(30);
    chk("t5_mode2_kept", int'(Mode), 2);
    host_req(1);
    wait_ack(200, "t5_ack_to1");
    tick(30);
    press_and_apply(2);
    press_and_apply(3);
    press_and_apply(4);
    press_and_apply(0);

    // 6: reset while a change is pending in mode 4
    host_req(4);
    wait_ack(5, "t6_ack_to4");
    chk("t6_mode4", int'(Mode), 4);
    IntBTN = 1'b1;
    tick(20);
    IntBTN = 1'b0;
    chk("t6_busy", int'(Busy), 1);
    tick(30);
    chk("t6_busy_held", int'(Busy), 1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    chk("t6_rst_mode", int'(Mode), 0);
    chk("t6_rst_enable", int'(Enable), 0);
    chk("t6_rst_ready", int'(Ready), 0);
    chk("t6_rst_busy", int'(Busy), 0);
    chk("t6_rst_ack", int'(HostAck), 0);
    chk("t6_rst_err", int'(HostErr), 0);
`ifdef SAMP_SCHED_STATUS_EN
    chk("t6_rst_drop", int'(DropCnt), 0);
`endif
    tick(79);
    chk("t6_ready_low_79", int'(Ready), 0);
    tick(1);
    chk("t6_ready_80", int'(Ready), 1);
    tick(30);
    chk("t6_mode_after", int'(Mode), 0);
    chk("t6_no_pending", int'(Busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/samp_rate_sched.md
Name: samp_rate_sched

Overview:
Sample-rate scheduler for the DDS function generator. It produces the sample-enable strobe that paces the waveform datapath. Rate-change requests come from the front-panel button and from a host register interface; the block arbitrates them and applies a new rate only on a sample boundary, so the output waveform is never given a partial sample period. It also sequences the power-up interval after reset.

Parameters:
NUM_MODES, 5, number of rate modes; divisors are 1, 10, 100, 1000, 10000 for modes 0..4.
CNT_W, 15, width of the divider counter; must hold 9999.
DEB_CYC, 16, number of consecutive cycles the synchronised button level must be stable before it is accepted.
STARTUP_CYC, 80, number of cycles from reset release until Ready rises.

Ports:
Fg_CLK  in  1  system clock; all logic on its rising edge.
RESET  in  1  synchronous, active-high reset.
IntBTN  in  1  raw, asynchronous front-panel button.
HostReq  in  1  host rate-change request; one-cycle pulse.
HostMode  in  3  requested mode; sampled when HostReq=1.
HostAck  out  1  one-cycle pulse when the host's mode is applied.
HostErr  out  1  one-cycle pulse when a host request is rejected.
Mode  out  3  currently active mode.
Enable  out  1  sample-enable strobe to the datapath.
Ready  out  1  high once the startup interval has completed.
Busy  out  1  high while a mode change is pending.

Behaviour:
- Clock and reset: one clock, Fg_CLK. Reset is synchronous and active-high (RESET). All outputs are registered.
- Reset values: Mode=0, Enable=0, Ready=0, Busy=0, HostAck=0, HostErr=0. Also cleared: divider counter, debounce state, button synchroniser, pending slot. FSM goes to STARTUP.
- RESET asserted mid-operation: state is cleared at the next edge and any pending request is discarded.
- STARTUP: counter runs 0..STARTUP_CYC-1. Ready goes high STARTUP_CYC cycles after RESET deasserts, then the FSM moves to RUN. During STARTUP, Enable=0 and all requests are ignored (no HostAck, no HostErr).
- Button path: 2-flop synchroniser, then a debounce counter. An accepted 0->1 transition produces one press event. Holding the button gives exactly one event.
- Divider, mode 0: Enable=1 continuously while Ready=1.
- Divider, mode k>0: counter counts 0..div-1. Enable is a one-cycle pulse registered the cycle after counter==div-1. Period is exactly div cycles.
- RUN: on a valid request, load the pending slot and go to PEND. Busy=1 from the next cycle.
  - Host request: target = HostMode.
  - Button request: target = (Mode==NUM_MODES-1) ? 0 : Mode+1.
- Invalid host request (HostMode>=NUM_MODES): HostErr pulses the next cycle. State is unchanged.
- Simultaneous host and button request: host wins; the button event is dropped.
- PEND: the change is applied at the next sample boundary, i.e. a cycle with Enable=1 (in mode 0, the next cycle).
  - At the following edge: Mode=target, divider counter=0, Busy=0, FSM returns to RUN.
  - HostAck=1 in that same cycle if the request came from the host.
  - First Enable in the new mode k>0 occurs div(k) cycles after Mode changes.
- Requests arriving in PEND:
  - A host request replaces a pending button target. The host is acked on apply.
  - A button event is dropped.
  - A second host request replaces the earlier host target. The earlier request receives neither ack nor error.
- Target equal to current Mode: the change is still applied at the boundary. The divider restarts and HostAck is still issued for a host request.

Optional Feature:
SAMP_SCHED_STATUS_EN.
- Defined: adds output DropCnt [7:0], a saturating count (stops at 255) of dropped or overridden requests. Cleared by RESET.
- Undefined: DropCnt port and its logic are absent; everything else is identical.

Test Plan:
1. Release RESET -> Ready=0 for 80 cycles, Ready=1 at cycle 80; Enable=1 continuously from cycle 80; Mode=0.
2. After Ready, press IntBTN cleanly (>16 cycles) -> Mode=1 within 1 cycle of the boundary; Enable pulses every 10 cycles, first pulse 10 cycles after the change; a button held for 1000 cycles gives exactly one change.
3. In mode 3, HostReq with HostMode=1 at divider count 200 -> Busy=1, Mode stays 3 until the 1000-cycle boundary; then Mode=1 and HostAck pulses once; next Enable 10 cycles later.
4. HostReq with HostMode=6 -> HostErr one pulse; Mode, Busy and Enable period unchanged.
5. HostReq(2) and a button event in the same cycle while in mode 0 -> Mode=2, HostAck=1; DropCnt=1 when SAMP_SCHED_STATUS_EN is defined; button press 4 times from mode 1 wraps 1->2->3->4->0.
6. RESET pulsed for 1 cycle while Busy=1 in mode 4 -> all outputs return to reset values, pending request discarded, STARTUP restarts (Ready again at 80 cycles).
